dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Handshake/bus bundle between the pipeline MEM stage (master) and the data
// memory responder (slave). Signal suffixes are from the responder's viewpoint.
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;
  logic        stall_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o, err_o, stall_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o, err_o, stall_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word-addressed data memory behind a req/ack handshake; holds
// the pipeline frozen while an access is in flight and flags illegal addresses.
module dmem_responder #(
  parameter int unsigned ADDR_WORDS = 256,
  parameter int unsigned LATENCY    = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q;
  logic             ack_q;
  logic             err_q;
  logic [31:0]      mem_q [ADDR_WORDS];

  logic             commit_s;
  logic             cur_we_s;
  logic [31:0]      cur_addr_s;
  logic [31:0]      cur_wdata_s;
  logic             legal_s;
  logic [IDX_W-1:0] idx_s;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:IDX_W+2] == '0);
  endfunction

  // With LATENCY=1 the commit edge is the accept edge, so IDLE uses the live request.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we_s    = bus.we_i;
      cur_addr_s  = bus.addr_i;
      cur_wdata_s = bus.wdata_i;
    end else begin
      cur_we_s    = we_q;
      cur_addr_s  = addr_q;
      cur_wdata_s = wdata_q;
    end
    legal_s = addr_legal(cur_addr_s);
    idx_s   = cur_addr_s[IDX_W+1:2];
  end

  // Next-state logic; commit_s marks the edge that enters DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    commit_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          addr_d  = bus.addr_i;
          wdata_d = bus.wdata_i;
          if (LATENCY == 1) begin
            state_d  = S_DONE;
            cnt_d    = 4'd0;
            commit_s = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d  = S_DONE;
          cnt_d    = 4'd0;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        // The request still visible here is the one completing; never re-accept it.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, latched request and registered completion outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= commit_s;
      err_q   <= commit_s & ~legal_s;
      if (commit_s) begin
        if (!legal_s) begin
          rdata_q <= 32'h0000_0000;
        end else if (!cur_we_s) begin
          rdata_q <= mem_q[idx_s];
        end
      end
    end
  end

  // Storage array is deliberately outside reset so contents survive it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit_s && legal_s && cur_we_s) begin
      mem_q[idx_s] <= cur_wdata_s;
    end
  end

  assign bus.rdata_o = rdata_q;
  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.stall_o = ((state_q == S_IDLE) && bus.req_i) || (state_q == S_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder at LATENCY=4 and LATENCY=1
// against a word-array reference model.
module tb_dmem_responder;
  localparam int WORDS = 256;

  bit   clk = 1'b0;
  logic rst4, rst1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [31:0] mdl4 [WORDS];
  logic [31:0] mdl1 [WORDS];
  logic [31:0] lr4, lr1;

  dmem_responder_if b4 ();
  dmem_responder_if b1 ();

  dmem_responder #(.ADDR_WORDS(WORDS), .LATENCY(4)) dut4 (.clk_i(clk), .rst_i(rst4), .bus(b4));
  dmem_responder #(.ADDR_WORDS(WORDS), .LATENCY(1)) dut1 (.clk_i(clk), .rst_i(rst1), .bus(b1));

  always #5 clk = ~clk;

  function automatic int lat_of(input bit f);
    return f ? 1 : 4;
  endfunction

  function automatic logic [34:0] samp(input bit f);
    if (f) return {b1.ack_o, b1.err_o, b1.stall_o, b1.rdata_o};
    else   return {b4.ack_o, b4.err_o, b4.stall_o, b4.rdata_o};
  endfunction

  task automatic drive(input bit f, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (f) begin
      b1.req_i = r; b1.we_i = w; b1.addr_i = a; b1.wdata_i = d;
    end else begin
      b4.req_i = r; b4.we_i = w; b4.addr_i = a; b4.wdata_i = d;
    end
  endtask

  // Reference: a word array; illegal -> err and zero data; store leaves rdata alone.
  task automatic model(input bit f, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic e, output logic [31:0] rd);
    int unsigned word;
    bit ok;
    word = a / 32'd4;
    ok   = (a % 32'd4 == 32'd0) && (word < WORDS);
    e    = !ok;
    if (!ok) rd = 32'h0;
    else if (w) begin
      rd = f ? lr1 : lr4;
      if (f) mdl1[word] = d; else mdl4[word] = d;
    end else rd = f ? mdl1[word] : mdl4[word];
    if (f) lr1 = rd; else lr4 = rd;
  endtask

  // One access: returns cycles from accept to ack (-1 on timeout) and stall count.
  task automatic xact(input bit f, input logic w, input logic [31:0] a, input logic [31:0] d, input bit drop,
                      output int lat, output int stalls, output logic e, output logic [31:0] rd);
    logic [34:0] s;
    lat = -1; stalls = 0; e = 1'bx; rd = 32'hxxxx_xxxx;
    @(posedge clk); #1; drive(f, 1'b1, w, a, d);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); s = samp(f);
      if (s[32] === 1'b1) stalls++;
      if (s[34] === 1'b1) begin lat = c; e = s[33]; rd = s[31:0]; break; end
      @(posedge clk); #1;
      if (drop) drive(f, 1'b0, ~w, $urandom, $urandom);
    end
    @(posedge clk); #1; drive(f, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic watch_acks(input bit f, input int n, output int acks, output int errs);
    logic [34:0] s;
    acks = 0; errs = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk); s = samp(f);
      if (s[34] !== 1'b0) acks++;
      if (s[34] === 1'b0 && s[33] !== 1'b0) errs++;
    end
  endtask

  task automatic test_reset;
    int acks, errs;
    rst4 = 1'b1; rst1 = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (samp(1'b0) !== 35'h0) begin n_fail++; $display("FAIL reset_outs_l4: got %h want 0", samp(1'b0)); end
    n_cmp++; if (samp(1'b1) !== 35'h0) begin n_fail++; $display("FAIL reset_outs_l1: got %h want 0", samp(1'b1)); end
    @(posedge clk); #1;
    rst4 = 1'b0; rst1 = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (b4.stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall_l4: got %b want 1", b4.stall_o); end
    n_cmp++; if (b1.stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall_l1: got %b want 1", b1.stall_o); end
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    watch_acks(1'b0, 10, acks, errs);
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL reset_no_ack: got %0d acks want 0", acks); end
    lr4 = 32'h0; lr1 = 32'h0;
  endtask

  task automatic test_init(input bit f);
    int lat, st; logic e, ee; logic [31:0] rd, erd, d;
    for (int i = 0; i < WORDS; i++) begin
      d = $urandom;
      model(f, 1'b1, 32'(i) * 32'd4, d, ee, erd);
      xact(f, 1'b1, 32'(i) * 32'd4, d, 1'b0, lat, st, e, rd);
      n_cmp++;
      if (lat !== lat_of(f) || e !== 1'b0)
        begin n_fail++; $display("FAIL init_store[%0d]: got lat %0d err %b want lat %0d err 0", i, lat, e, lat_of(f)); end
    end
  endtask

  task automatic test_store_load;
    int lat, st; logic e, ee; logic [31:0] rd, erd;
    model(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ee, erd);
    xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, st, e, rd);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL st_lat: got %0d want 4", lat); end
    n_cmp++; if (st !== 4) begin n_fail++; $display("FAIL st_stalls: got %0d want 4", st); end
    n_cmp++; if (e !== 1'b0) begin n_fail++; $display("FAIL st_err: got %b want 0", e); end
    n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL st_rdata_hold: got %h want %h", rd, erd); end
    model(1'b0, 1'b0, 32'h10, 32'h0, ee, erd);
    xact(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, lat, st, e, rd);
    n_cmp++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL ld_after_st: got %h err %b want deadbeef err 0", rd, e); end
  endtask

  task automatic test_misaligned;
    int lat, st; logic e, ee; logic [31:0] rd, erd;
    model(1'b0, 1'b0, 32'h6, 32'h0, ee, erd);
    xact(1'b0, 1'b0, 32'h6, 32'h0, 1'b0, lat, st, e, rd);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL mis_lat: got %0d want 4", lat); end
    n_cmp++; if (e !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL mis_err: got err %b data %h want err 1 data 0", e, rd); end
    model(1'b0, 1'b0, 32'h4, 32'h0, ee, erd);
    xact(1'b0, 1'b0, 32'h4, 32'h0, 1'b0, lat, st, e, rd);
    n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL mis_word1: got %h want %h", rd, erd); end
  endtask

  task automatic test_out_of_range;
    int lat, st; logic e, ee; logic [31:0] rd, erd;
    model(1'b0, 1'b1, 32'h400, 32'hA5A5_5A5A, ee, erd);
    xact(1'b0, 1'b1, 32'h400, 32'hA5A5_5A5A, 1'b0, lat, st, e, rd);
    n_cmp++; if (lat !== 4 || e !== 1'b1) begin n_fail++; $display("FAIL oor_err: got lat %0d err %b want lat 4 err 1", lat, e); end
    model(1'b0, 1'b0, 32'h0, 32'h0, ee, erd);
    xact(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, lat, st, e, rd);
    n_cmp++; if (rd !== erd || e !== 1'b0) begin n_fail++; $display("FAIL oor_word0: got %h err %b want %h err 0", rd, e, erd); end
  endtask

  task automatic test_drop;
    int lat, st, acks, errs; logic e, ee; logic [31:0] rd, erd;
    model(1'b0, 1'b0, 32'h8, 32'h0, ee, erd);
    xact(1'b0, 1'b0, 32'h8, 32'h0, 1'b1, lat, st, e, rd);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL drop_lat: got %0d want 4", lat); end
    n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL drop_rdata: got %h want %h", rd, erd); end
    watch_acks(1'b0, 12, acks, errs);
    n_cmp++; if (acks !== 0 || errs !== 0) begin n_fail++; $display("FAIL drop_extra: got %0d acks %0d errs want 0", acks, errs); end
  endtask

  // Store aborted by reset asserted during cycle T+when of the access.
  task automatic test_reset_mid(input int when, input logic [31:0] a);
    int lat, st, acks, errs; logic e, ee; logic [31:0] rd, erd; logic [34:0] s;
    @(posedge clk); #1; drive(1'b0, 1'b1, 1'b1, a, 32'h55);
    for (int c = 1; c <= when; c++) begin @(posedge clk); #1; end
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0; drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    lr4 = 32'h0;
    watch_acks(1'b0, 8, acks, errs);
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rstmid%0d_ack: got %0d acks want 0", when, acks); end
    s = samp(1'b0);
    n_cmp++; if (s[32:0] !== 33'h0) begin n_fail++; $display("FAIL rstmid%0d_idle: got %h want 0", when, s[32:0]); end
    model(1'b0, 1'b0, a, 32'h0, ee, erd);
    xact(1'b0, 1'b0, a, 32'h0, 1'b0, lat, st, e, rd);
    n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL rstmid%0d_old: got %h want %h", when, rd, erd); end
  endtask

  task automatic test_back_to_back(input bit f);
    int L, acks, errs; logic [34:0] s; logic e0, e1; logic [31:0] r0, r1;
    L = lat_of(f);
    model(f, 1'b0, 32'h8, 32'h0, e0, r0);
    model(f, 1'b0, 32'hC, 32'h0, e1, r1);
    for (int c = 0; c < 2 * L + 2; c++) begin
      @(posedge clk); #1;
      drive(f, 1'b1, 1'b0, (c <= L) ? 32'h8 : 32'hC, 32'h0);
      @(negedge clk); s = samp(f);
      n_cmp++; if (s[34] !== ((c == L) || (c == 2 * L + 1)))
        begin n_fail++; $display("FAIL b2b_l%0d_ack[%0d]: got %b", L, c, s[34]); end
      n_cmp++; if (s[32] !== ((c % (L + 1)) != L))
        begin n_fail++; $display("FAIL b2b_l%0d_stall[%0d]: got %b", L, c, s[32]); end
      if (c == L) begin
        n_cmp++; if (s[31:0] !== r0) begin n_fail++; $display("FAIL b2b_l%0d_rd0: got %h want %h", L, s[31:0], r0); end
      end
      if (c == 2 * L + 1) begin
        n_cmp++; if (s[31:0] !== r1) begin n_fail++; $display("FAIL b2b_l%0d_rd1: got %h want %h", L, s[31:0], r1); end
      end
    end
    @(posedge clk); #1; drive(f, 1'b0, 1'b0, 32'h0, 32'h0);
    watch_acks(f, 2 * L + 4, acks, errs);
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL b2b_l%0d_tail: got %0d acks want 0", L, acks); end
  endtask

  task automatic test_random(input bit f, input int n);
    int lat, st, k; logic e, ee, w; logic [31:0] rd, erd, a, d; bit drop;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (k <= 6)      a = 32'($urandom_range(0, WORDS - 1)) * 32'd4;
      else if (k == 7) a = 32'($urandom_range(0, WORDS - 1)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (k == 8) a = 32'(WORDS * 4) + 32'($urandom_range(0, 65535));
      else             a = $urandom;
      drop = ($urandom_range(0, 3) == 0);
      model(f, w, a, d, ee, erd);
      xact(f, w, a, d, drop, lat, st, e, rd);
      n_cmp++; if (lat !== lat_of(f)) begin n_fail++; $display("FAIL rand%0d_lat[%0d]: got %0d want %0d", f, i, lat, lat_of(f)); end
      n_cmp++; if (st !== lat_of(f)) begin n_fail++; $display("FAIL rand%0d_stall[%0d]: got %0d want %0d", f, i, st, lat_of(f)); end
      n_cmp++; if (e !== ee) begin n_fail++; $display("FAIL rand%0d_err[%0d] a=%h: got %b want %b", f, i, a, e, ee); end
      n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL rand%0d_rdata[%0d] a=%h: got %h want %h", f, i, a, rd, erd); end
    end
  endtask

  initial begin
    test_reset;
    test_init(1'b0);
    test_init(1'b1);
    test_store_load;
    test_misaligned;
    test_out_of_range;
    test_drop;
    test_reset_mid(2, 32'h20);
    test_reset_mid(3, 32'h24);
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_random(1'b0, 150);
    test_random(1'b1, 80);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
